// File: rtl/axi_read_arbiter_pkg.sv
// Shared types for the two-port AXI read arbiter.
// Port numbering and arbiter state encoding.
package axi_read_arbiter_pkg;

  localparam int ARB_PORTS = 2;
  localparam int PORT_IF   = 0;
  localparam int PORT_LS   = 1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RELEASE
  } arb_state_e;

endpackage

// File: rtl/axi_read_arbiter_rr_pick2.sv
// Two-way round-robin pick.
// With both ports requesting, the one not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any   = |req;
    grant = 1'b0;
    if (req == 2'b11)
      grant = ~last;
    else if (req[1])
      grant = 1'b1;
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin merge of fetch and load/store reads onto one
// axi_read_master ctrl port; routes beats and done back.
import axi_read_arbiter_pkg::*;

module axi_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ARB_PORTS-1:0]             req_i,
  input  logic [ARB_PORTS-1:0][ADDR_W-1:0] addr_i,
  input  logic [ARB_PORTS-1:0][LEN_W-1:0]  len_i,
  output logic [DATA_W-1:0]                rdata_o,
  output logic [ARB_PORTS-1:0]             rvalid_o,
  output logic [ARB_PORTS-1:0]             done_o,
  output logic                             m_read_req,
  output logic [ADDR_W-1:0]                m_read_addr,
  output logic [LEN_W-1:0]                 m_read_len,
  input  logic [DATA_W-1:0]                m_read_data,
  input  logic                             m_read_data_valid,
  input  logic                             m_read_done
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic                 grant_q;
  logic                 last_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LEN_W-1:0]     len_q;
  logic [ARB_PORTS-1:0] done_q;

  logic pick;
  logic any;
  logic load;
  logic finish;
  logic busy;

  rr_pick2 u_pick (
    .req   (req_i),
    .last  (last_q),
    .grant (pick),
    .any   (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ARB_IDLE;
    else
      state_q <= state_d;
  end

  // RELEASE ignores m_read_done so a level-style done
  // cannot finish a second, never-issued burst.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (any) begin
          load    = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (m_read_done) begin
          finish  = 1'b1;
          state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      len_q   <= '0;
      done_q  <= '0;
    end else begin
      done_q <= '0;
      if (load) begin
        grant_q <= pick;
        addr_q  <= addr_i[pick];
        len_q   <= len_i[pick];
      end
      if (finish) begin
        done_q[grant_q] <= 1'b1;
        last_q          <= grant_q;
      end
    end
  end

  assign busy        = (state_q == ARB_BUSY);
  assign m_read_req  = busy;
  assign m_read_addr = addr_q;
  assign m_read_len  = len_q;
  assign done_o      = done_q;
  assign rdata_o     = busy ? m_read_data : '0;

  always_comb begin
    rvalid_o = '0;
    if (busy && m_read_data_valid)
      rvalid_o[grant_q] = 1'b1;
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter.
// The bench plays the master: word at byte addr a is a>>2.
module tb_axi_read_arbiter;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_i;
  logic [1:0][31:0] addr_i;
  logic [1:0][7:0]  len_i;
  logic [31:0]      rdata_o;
  logic [1:0]       rvalid_o;
  logic [1:0]       done_o;
  logic             m_read_req;
  logic [31:0]      m_read_addr;
  logic [7:0]       m_read_len;
  logic [31:0]      m_data;
  logic             m_valid;
  logic             m_done;

  int n_cmp;
  int n_fail;

  axi_read_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .LEN_W  (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_i             (req_i),
    .addr_i            (addr_i),
    .len_i             (len_i),
    .rdata_o           (rdata_o),
    .rvalid_o          (rvalid_o),
    .done_o            (done_o),
    .m_read_req        (m_read_req),
    .m_read_addr       (m_read_addr),
    .m_read_len        (m_read_len),
    .m_read_data       (m_data),
    .m_read_data_valid (m_valid),
    .m_read_done       (m_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for m_read_req, plays the burst, checks done and release.
  task automatic serve_burst(input int port, input logic [31:0] a,
                             input logic [7:0] l, input bit drop,
                             output int waited);
    logic [1:0] exp;
    exp = 2'b01 << port;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (m_read_req !== 1'b1 && waited < 20);
    n_cmp++;
    if (m_read_req !== 1'b1) begin
      $display("FAIL req_timeout port=%0d got=%b want=1", port, m_read_req);
      n_fail++;
      return;
    end
    n_cmp++;
    if (m_read_addr !== a) begin
      $display("FAIL m_read_addr got=%h want=%h", m_read_addr, a);
      n_fail++;
    end
    n_cmp++;
    if (m_read_len !== l) begin
      $display("FAIL m_read_len got=%h want=%h", m_read_len, l);
      n_fail++;
    end
    for (int i = 0; i <= int'(l); i++) begin
      m_valid = 1'b1;
      m_data  = (a >> 2) + 32'(i);
      #1;
      n_cmp++;
      if (rvalid_o !== exp || rdata_o !== (a >> 2) + 32'(i)) begin
        $display("FAIL beat%0d rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                 i, rvalid_o, rdata_o, exp, (a >> 2) + 32'(i));
        n_fail++;
      end
      @(negedge clk);
    end
    m_valid = 1'b0;
    m_done  = 1'b1;
    #1;
    n_cmp++;
    if (done_o !== 2'b00 || m_read_req !== 1'b1) begin
      $display("FAIL done_early done=%b req=%b want 00/1", done_o, m_read_req);
      n_fail++;
    end
    @(negedge clk);
    m_done = 1'b0;
    n_cmp++;
    if (done_o !== exp || m_read_req !== 1'b0) begin
      $display("FAIL done_pulse done=%b req=%b want %b/0", done_o, m_read_req, exp);
      n_fail++;
    end
    if (drop) req_i[port] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done_o !== 2'b00 || m_read_req !== 1'b0 || rvalid_o !== 2'b00) begin
      $display("FAIL release done=%b req=%b rvalid=%b want 00/0/00",
               done_o, m_read_req, rvalid_o);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    req_i   = '0;
    addr_i  = '0;
    len_i   = '0;
    m_data  = '0;
    m_valid = 1'b0;
    m_done  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (m_read_req !== 1'b0 || rvalid_o !== 2'b00 || done_o !== 2'b00 ||
        m_read_addr !== 32'h0 || m_read_len !== 8'h0 || rdata_o !== 32'h0) begin
      $display("FAIL reset_outputs req=%b rv=%b done=%b addr=%h len=%h want all 0",
               m_read_req, rvalid_o, done_o, m_read_addr, m_read_len);
      n_fail++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    int w;
    req_i     = 2'b01;
    addr_i[0] = 32'h04;
    len_i[0]  = 8'd0;
    #1;
    n_cmp++;
    if (m_read_req !== 1'b0) begin
      $display("FAIL latency_early got=%b want=0", m_read_req);
      n_fail++;
    end
    serve_burst(0, 32'h04, 8'd0, 1'b1, w);
    n_cmp++;
    if (w !== 1) begin
      $display("FAIL grant_latency got=%0d want=1", w);
      n_fail++;
    end
  endtask

  task automatic test_burst_port1();
    int w;
    req_i     = 2'b10;
    addr_i[1] = 32'h40;
    len_i[1]  = 8'd7;
    serve_burst(1, 32'h40, 8'd7, 1'b1, w);
  endtask

  task automatic test_simultaneous();
    int w;
    test_reset();
    addr_i[0] = 32'h10;
    len_i[0]  = 8'd1;
    addr_i[1] = 32'h20;
    len_i[1]  = 8'd0;
    req_i     = 2'b11;
    serve_burst(0, 32'h10, 8'd1, 1'b1, w);
    serve_burst(1, 32'h20, 8'd0, 1'b1, w);
    n_cmp++;
    if (w !== 1) begin
      $display("FAIL release_gap got=%0d want=1", w);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int w;
    test_reset();
    addr_i[0] = 32'h100;
    len_i[0]  = 8'd1;
    addr_i[1] = 32'h200;
    len_i[1]  = 8'd2;
    req_i     = 2'b11;
    serve_burst(0, 32'h100, 8'd1, 1'b0, w);
    serve_burst(1, 32'h200, 8'd2, 1'b0, w);
    serve_burst(0, 32'h100, 8'd1, 1'b1, w);
    serve_burst(1, 32'h200, 8'd2, 1'b1, w);
    n_cmp++;
    if (w !== 1) begin
      $display("FAIL b2b_latency got=%0d want=1", w);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int w;
    req_i     = 2'b01;
    addr_i[0] = 32'h80;
    len_i[0]  = 8'd7;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (m_read_req !== 1'b1 && w < 20);
    n_cmp++;
    if (m_read_req !== 1'b1) begin
      $display("FAIL rst_burst_start got=%b want=1", m_read_req);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      m_valid = 1'b1;
      m_data  = 32'h20 + 32'(i);
      @(negedge clk);
    end
    m_data = 32'h23;
    #1;
    n_cmp++;
    if (rvalid_o !== 2'b01 || rdata_o !== 32'h23) begin
      $display("FAIL beat3 rvalid=%b rdata=%h want 01/23", rvalid_o, rdata_o);
      n_fail++;
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_read_req !== 1'b0 || rvalid_o !== 2'b00 || done_o !== 2'b00 ||
        m_read_addr !== 32'h0 || m_read_len !== 8'h0 || rdata_o !== 32'h0) begin
      $display("FAIL async_reset req=%b rv=%b done=%b addr=%h len=%h rdata=%h want all 0",
               m_read_req, rvalid_o, done_o, m_read_addr, m_read_len, rdata_o);
      n_fail++;
    end
    req_i   = 2'b00;
    m_valid = 1'b0;
    m_data  = '0;
    @(negedge clk);
    rst_n     = 1'b1;
    @(negedge clk);
    addr_i[1] = 32'h44;
    len_i[1]  = 8'd0;
    req_i     = 2'b10;
    serve_burst(1, 32'h44, 8'd0, 1'b1, w);
    n_cmp++;
    if (w !== 1) begin
      $display("FAIL post_reset_latency got=%0d want=1", w);
      n_fail++;
    end
  endtask

  task automatic test_stray_idle();
    int w;
    req_i   = 2'b00;
    m_valid = 1'b1;
    m_done  = 1'b1;
    m_data  = 32'hdead_beef;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (rvalid_o !== 2'b00 || done_o !== 2'b00 || m_read_req !== 1'b0) begin
        $display("FAIL stray%0d rv=%b done=%b req=%b want 00/00/0",
                 i, rvalid_o, done_o, m_read_req);
        n_fail++;
      end
      @(negedge clk);
    end
    m_valid   = 1'b0;
    m_done    = 1'b0;
    addr_i[0] = 32'h08;
    len_i[0]  = 8'd0;
    req_i     = 2'b01;
    serve_burst(0, 32'h08, 8'd0, 1'b1, w);
    n_cmp++;
    if (w !== 1) begin
      $display("FAIL stray_then_idle got=%0d want=1", w);
      n_fail++;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single_beat();
    test_burst_port1();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_burst();
    test_stray_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
